// File: rtl/mod_unit.sv
// Sequential unsigned modulus (RES = A mod B), restoring shift-subtract, one bit per clock.
// Optional DIV_ZERO flag output is enabled by defining MOD_DIVZERO_FLAG_EN.
module mod_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] RES,
    output logic             BUSY,
    output logic             DONE
`ifdef MOD_DIVZERO_FLAG_EN
    ,
    output logic             DIV_ZERO
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [WIDTH:0]   r;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   r_next;
    logic [CNT_W-1:0] cnt;

    // One extra bit on the partial remainder keeps the shifted-out carry for all-ones divisors.
    always_comb begin
        r_shift = {r[WIDTH-1:0], q[WIDTH-1]};
        if (r_shift >= {1'b0, d}) begin
            r_next = r_shift - {1'b0, d};
        end else begin
            r_next = r_shift;
        end
    end

    assign BUSY = (state != S_IDLE);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
            q     <= '0;
            d     <= '0;
            r     <= '0;
            cnt   <= '0;
            RES   <= '0;
            DONE  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        q   <= A;
                        d   <= B;
                        r   <= '0;
                        cnt <= '0;
                        if (B == '0) begin
                            // Mod-by-zero returns the dividend without iterating.
                            RES   <= A;
                            DONE  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            state <= S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    q   <= q << 1;
                    r   <= r_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        RES   <= r_next[WIDTH-1:0];
                        DONE  <= 1'b1;
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    DONE  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    DONE  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MOD_DIVZERO_FLAG_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            DIV_ZERO <= 1'b0;
        end else if (state == S_IDLE && START) begin
            DIV_ZERO <= (B == '0);
        end
    end
`endif

endmodule

// File: tb/tb_mod_unit.sv
// Scoreboard bench for mod_unit: driver queues expected results, monitor checks on each DONE.
module tb_mod_unit;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RESET_N = 1'b0;
    logic         START = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] RES;
    logic         BUSY;
    logic         DONE;
`ifdef MOD_DIVZERO_FLAG_EN
    logic         DIV_ZERO;
`endif

    mod_unit #(
        .WIDTH(W),
        .CNT_W(6)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .START   (START),
        .A       (A),
        .B       (B),
        .RES     (RES),
        .BUSY    (BUSY),
        .DONE    (DONE)
`ifdef MOD_DIVZERO_FLAG_EN
        ,
        .DIV_ZERO(DIV_ZERO)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] res;
        int unsigned  cap;
        int unsigned  lat;
        logic         dz;
    } exp_t;

    exp_t        sbq[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    logic        prev_done = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Latency = posedges from the capture edge to the edge that raised DONE.
    always @(negedge CLK) begin
        exp_t e;
        if (RESET_N && DONE) begin
            check("done_one_cycle", {63'd0, prev_done}, 64'd0);
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got DONE with RES=%0h, expected no result", RES);
            end else begin
                e = sbq.pop_front();
                check("res", {32'd0, RES}, {32'd0, e.res});
                check("latency", 64'(cyc - e.cap), 64'(e.lat));
`ifdef MOD_DIVZERO_FLAG_EN
                check("div_zero", {63'd0, DIV_ZERO}, {63'd0, e.dz});
`endif
            end
        end
        prev_done = DONE;
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] res, input int unsigned lat,
                          input logic dz, input bit track);
        exp_t e;
        @(negedge CLK);
        A     = a;
        B     = b;
        START = 1'b1;
        e.res = res;
        e.cap = cyc + 1;
        e.lat = lat;
        e.dz  = dz;
        if (track) sbq.push_back(e);
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (sbq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge CLK);
        check("rst_res", {32'd0, RES}, 64'd0);
        check("rst_busy", {63'd0, BUSY}, 64'd0);
        check("rst_done", {63'd0, DONE}, 64'd0);
        RESET_N = 1'b1;

        run_op(32'd17, 32'd5, 32'd2, 32, 1'b0, 1'b1);
        check("busy_after_capture", {63'd0, BUSY}, 64'd1);
        wait_drain();
        @(negedge CLK);
        check("busy_after_fin", {63'd0, BUSY}, 64'd0);
        check("done_after_fin", {63'd0, DONE}, 64'd0);

        run_op(32'd3, 32'd10, 32'd3, 32, 1'b0, 1'b1);
        wait_drain();
        run_op(32'd0, 32'd9, 32'd0, 32, 1'b0, 1'b1);
        wait_drain();
        run_op(32'hFFFF_FFFF, 32'd7, 32'd3, 32, 1'b0, 1'b1);
        wait_drain();
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32, 1'b0, 1'b1);
        wait_drain();
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32, 1'b0, 1'b1);
        wait_drain();

        // Divide by zero finishes on the capture edge and returns the dividend.
        run_op(32'd123, 32'd0, 32'd123, 0, 1'b1, 1'b1);
        wait_drain();
        repeat (3) @(negedge CLK);
        check("res_hold_idle", {32'd0, RES}, 64'd123);
`ifdef MOD_DIVZERO_FLAG_EN
        check("div_zero_hold", {63'd0, DIV_ZERO}, 64'd1);
`endif
        run_op(32'd20, 32'd6, 32'd2, 32, 1'b0, 1'b1);
`ifdef MOD_DIVZERO_FLAG_EN
        check("div_zero_clear", {63'd0, DIV_ZERO}, 64'd0);
`endif
        wait_drain();

        // START during ITER is ignored; operand changes mid-run do not matter.
        run_op(32'd100, 32'd7, 32'd2, 32, 1'b0, 1'b1);
        repeat (9) @(negedge CLK);
        A     = 32'd50;
        B     = 32'd3;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        A     = 32'hDEAD_BEEF;
        B     = 32'd0;
        wait_drain();
        repeat (4) @(negedge CLK);
        check("no_restart", {63'd0, BUSY}, 64'd0);

        // Asynchronous reset between edges in the middle of an operation.
        run_op(32'd1000, 32'd33, 32'd10, 32, 1'b0, 1'b0);
        repeat (14) @(posedge CLK);
        #2;
        RESET_N = 1'b0;
        #1;
        check("async_rst_res", {32'd0, RES}, 64'd0);
        check("async_rst_busy", {63'd0, BUSY}, 64'd0);
        check("async_rst_done", {63'd0, DONE}, 64'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);
        check("idle_after_rst", {63'd0, BUSY}, 64'd0);
        run_op(32'd1000, 32'd33, 32'd10, 32, 1'b0, 1'b1);
        wait_drain();

        repeat (3) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
